// File: rtl/muldiv_pkg.sv
// Shared encodings and latched-operation control for the multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_e;

   // Per-operation flags captured at start and consumed in FIN.
   typedef struct packed {
      logic is_div;
      logic neg_q;   // negate product (mul) or quotient (div)
      logic neg_r;   // negate remainder: dividend was negative
      logic div0;    // divisor was zero
   } ctrl_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             is_div,
   output logic [WIDTH:0]   acc_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = q[0] ? acc + {1'b0, d} : acc;
      sh      = {acc[WIDTH-1:0], q[WIDTH-1]};
      diff    = sh - {1'b0, d};
      acc_nxt = {1'b0, sum[WIDTH:1]};
      q_nxt   = {sum[0], q[WIDTH-1:1]};
      if (is_div) begin
         // acc < d holds between steps, so bit WIDTH of diff is a true borrow
         if (!diff[WIDTH]) begin
            acc_nxt = diff;
            q_nxt   = {q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = sh;
            q_nxt   = {q[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             hilo_wr,
   input  logic             hilo_sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e               state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [WIDTH:0]       acc, acc_nxt;
   logic [WIDTH-1:0]     q, q_nxt, d;
   ctrl_t                ctrl;
   logic [WIDTH-1:0]     hi_q, lo_q, res_hi, res_lo;
   logic                 sgn, a_neg, b_neg;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [2*WIDTH-1:0]   prod;

   always_comb begin
      sgn   = (op == OP_MULT) || (op == OP_DIV);
      a_neg = sgn & busA[WIDTH-1];
      b_neg = sgn & busB[WIDTH-1];
      a_abs = a_neg ? -busA : busA;
      b_abs = b_neg ? -busB : busB;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc),
      .q       (q),
      .d       (d),
      .is_div  (ctrl.is_div),
      .acc_nxt (acc_nxt),
      .q_nxt   (q_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (cnt == '0) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_FIN);
   end

   // Sign correction; div-by-zero remainder comes out as |busA| and is re-signed here too
   always_comb begin
      prod   = {acc[WIDTH-1:0], q};
      res_hi = ctrl.neg_q ? prod_neg(prod, 1'b1) : prod[2*WIDTH-1:WIDTH];
      res_lo = ctrl.neg_q ? prod_neg(prod, 1'b0) : prod[WIDTH-1:0];
      if (ctrl.is_div) begin
         res_lo = ctrl.div0 ? '1 : (ctrl.neg_q ? -q : q);
         res_hi = ctrl.neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
   end

   function automatic logic [WIDTH-1:0] prod_neg(input logic [2*WIDTH-1:0] p, input logic upper);
      logic [2*WIDTH-1:0] n;
      n = -p;
      return upper ? n[2*WIDTH-1:WIDTH] : n[WIDTH-1:0];
   endfunction

   // The result is visible during FIN so it lines up with the done pulse.
   assign hi = (state == S_FIN) ? res_hi : hi_q;
   assign lo = (state == S_FIN) ? res_lo : lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         acc  <= '0;
         q    <= '0;
         d    <= '0;
         ctrl <= '0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc         <= '0;
                  q           <= a_abs;
                  d           <= b_abs;
                  cnt         <= CW'(WIDTH - 1);
                  ctrl.is_div <= op[1];
                  ctrl.neg_q  <= a_neg ^ b_neg;
                  ctrl.neg_r  <= op[1] & a_neg;
                  ctrl.div0   <= op[1] & (busB == '0);
               end else if (hilo_wr) begin
                  if (hilo_sel) hi_q <= busA;
                  else          lo_q <= busA;
               end
            end
            S_RUN: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               cnt <= cnt - 1'b1;
            end
            S_FIN: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, collisions and reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst, start, hilo_wr, hilo_sel;
   logic [1:0]  op;
   logic [31:0] busA, busB;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .busA     (busA),
      .busB     (busB),
      .hilo_wr  (hilo_wr),
      .hilo_sel (hilo_sel),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; busA = a; busB = b;
      @(posedge clk); #1;
      start = 1'b0;
      busA  = $urandom;
      busB  = $urandom;
   endtask

   // Counts busy cycles up to and including the done cycle, starting from c0.
   task automatic wait_done(input string tag, input int c0, output int n);
      bit to;
      n  = c0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         @(posedge clk); #1;
         if (busy) n++;
      end
      chk({tag, ".timeout"}, 32'(to), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      int n;
      launch(o, a, b);
      chk({tag, ".busy0"}, 32'(busy), 32'd1);
      wait_done(tag, 1, n);
      chk({tag, ".cycles"}, 32'(n), 32'd33);
      chk({tag, ".hi"}, hi, ehi);
      chk({tag, ".lo"}, lo, elo);
      @(posedge clk); #1;
      chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
      chk({tag, ".hi_reg"}, hi, ehi);
      chk({tag, ".lo_reg"}, lo, elo);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; hilo_wr = 1'b0; hilo_sel = 1'b0;
      op = 2'b00; busA = '0; busB = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy_done", {30'd0, busy, done}, 32'd0);
      chk("rst.hi", hi, 32'd0);
      chk("rst.lo", lo, 32'd0);
      rst = 1'b0;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_n3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("div_n7d2",  2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7dn2",  2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("divu_7d0",  2'b11, 32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
      run_op("div_n8d0",  2'b10, 32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

      // MTHI / MTLO in idle
      @(negedge clk); hilo_wr = 1'b1; hilo_sel = 1'b1; busA = 32'h0000_CAFE;
      @(posedge clk); #1; hilo_wr = 1'b0;
      chk("mthi.hi", hi, 32'h0000_CAFE);
      chk("mthi.busy_done", {30'd0, busy, done}, 32'd0);
      @(negedge clk); hilo_wr = 1'b1; hilo_sel = 1'b0; busA = 32'h0000_BEEF;
      @(posedge clk); #1; hilo_wr = 1'b0;
      chk("mtlo.lo", lo, 32'h0000_BEEF);
      chk("mtlo.hi_kept", hi, 32'h0000_CAFE);

      // start and hilo_wr together: start wins
      @(negedge clk);
      start = 1'b1; op = 2'b01; busA = 32'd3; busB = 32'd4; hilo_wr = 1'b1; hilo_sel = 1'b0;
      @(posedge clk); #1; start = 1'b0; hilo_wr = 1'b0;
      chk("both.busy", 32'(busy), 32'd1);
      chk("both.lo_kept", lo, 32'h0000_BEEF);
      wait_done("both", 1, n);
      chk("both.lo", lo, 32'd12);
      chk("both.hi", hi, 32'd0);
      @(posedge clk); #1;

      // start and hilo_wr while busy are ignored
      launch(2'b01, 32'd5, 32'd6);
      repeat (4) begin @(posedge clk); #1; end
      @(negedge clk);
      start = 1'b1; op = 2'b11; busA = 32'd9; busB = 32'd3; hilo_wr = 1'b1; hilo_sel = 1'b0;
      @(posedge clk); #1; start = 1'b0; hilo_wr = 1'b0;
      wait_done("coll", 6, n);
      chk("coll.cycles", 32'(n), 32'd33);
      chk("coll.hi", hi, 32'd0);
      chk("coll.lo", lo, 32'd30);
      @(posedge clk); #1;
      chk("coll.idle", 32'(busy), 32'd0);

      // reset mid-run discards the operation
      launch(2'b01, 32'd11, 32'd13);
      repeat (9) begin @(posedge clk); #1; end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      chk("mrst.busy_done", {30'd0, busy, done}, 32'd0);
      chk("mrst.hi", hi, 32'd0);
      chk("mrst.lo", lo, 32'd0);
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) n++;
      end
      chk("mrst.no_activity", 32'(n), 32'd0);
      run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
